imem_loader: RTL and testbench
==============================

# imem_loader

Program loader on the write side of the CPU instruction memory. Accepts a byte stream over a valid/ready handshake, assembles 16-bit instruction words high byte first, and writes them into the 256-entry instruction memory the CPU fetches from. It holds the CPU in reset until a complete program has been written and signals completion; a new load can start at any later time.

## Interface
- ADDR_W, 8, instruction memory address width; the word counter is ADDR_W+1 bits.
- DATA_W, 16, instruction width; fixed at 2 bytes.
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- in_valid  in  1  byte on in_data is valid
- in_data  in  8  stream byte
- in_ready  out  1  loader accepts a byte this cycle
- imem_we  out  1  instruction memory write strobe
- imem_waddr  out  ADDR_W  write address
- imem_wdata  out  DATA_W  write data
- cpu_hold  out  1  CPU reset request; high while no valid program is present
- load_done  out  1  one-cycle pulse when a load completes successfully
- load_err  out  1  sticky checksum error (tied 0 when the checksum is compiled out)
- state_dbg  out  3  current FSM state

## Operation
- Frame: count byte N, then 2N data bytes, each word high byte then low byte; N=0 means 256 words. Words are written to addresses 0..N-1.
- A byte transfers on a rising edge with in_valid && in_ready. in_valid may drop at any time; no byte is lost or duplicated.
- States: IDLE=0, HI=1, LO=2, WRITE=3, CHK=4, DONE=5.
- IDLE: in_ready=1. On accepting the count byte: latch N, clear word index, clear load_err, set cpu_hold=1, go to HI.
- HI: in_ready=1. Latch the high byte, go to LO.
- LO: in_ready=1. Latch the low byte, go to WRITE.
- WRITE: in_ready=0. imem_we=1, imem_waddr=index[ADDR_W-1:0], imem_wdata={hi,lo} for exactly one cycle. If index==N-1 (or 255 when N=0), go to CHK (checksum enabled) or DONE; otherwise increment index and go to HI.
- CHK: in_ready=1. Compare the accepted byte to the running checksum. On a match, go to DONE. On a mismatch, set load_err=1, leave cpu_hold=1, and go to IDLE.
- DONE: load_done=1, cpu_hold←0, go to IDLE.
- imem_waddr and imem_wdata are 0 whenever imem_we=0.
- Words already written stay in memory after an error or reset; the loader never clears memory.

## Timing
- Reset values: state=IDLE, in_ready=1 (combinational from IDLE), imem_we=0, imem_waddr=0, imem_wdata=0, cpu_hold=1, load_done=0, load_err=0, state_dbg=0.
- imem_we is asserted in the cycle after the low byte's handshake edge.
- Minimum cycles per word: 3 (HI, LO, WRITE).
- Minimum load for N words: 1 + 3N cycles, plus 1 cycle for CHK when enabled, plus 1 cycle for DONE.
- cpu_hold falls on the edge leaving DONE; load_done is high during the DONE cycle only.
- cpu_hold rises on the edge that accepts a count byte, including when a new load follows a completed one.
- Reset mid-load: all FSM state, the counter and the checksum return to reset values on the next edge; a pending write is not issued.
- The index counter never wraps beyond N-1. For N=0, the final write is at address 0xFF.

## Configuration
- IMEM_LOADER_CHECKSUM_EN
  - Defined: the frame carries one trailing byte equal to the XOR of the count byte and all data bytes. The CHK state and the load_err logic are built. Completion requires a match.
  - Undefined: no trailing byte is expected. WRITE of the last word goes directly to DONE, CHK is unreachable, and load_err is constant 0.

## Test plan
- Basic load, macro undefined: bytes 04 15 12 26 43 37 67 45 53 with no gaps → writes (0,1512), (1,2643), (2,3767), (3,4553); load_done pulses once; cpu_hold goes 1→0; 14 cycles from the first handshake to load_done.
- Checksum, macro defined: the same frame plus 20 → load_done pulses and load_err=0. The same frame plus 21 instead → no load_done, load_err=1, cpu_hold stays 1; a following good frame clears load_err.
- Gaps and back-pressure: drop in_valid randomly between bytes and hold in_valid=1 during WRITE → in_ready=0 in every WRITE cycle, the same 4 writes occur, and no byte is duplicated.
- N=0: count byte 00 then 512 bytes, word k = k*0x0101 → 256 writes with the last at address FF and data FFFF; exactly one load_done.
- Reset mid-load: assert reset after the high byte of word 2 → no write to address 2, state=IDLE, cpu_hold=1; a following 1-word frame 01 AB CD writes (0,ABCD).

Source files
------------

// File: rtl/imem_loader.sv
// imem_loader
//   Program loader on the write side of the CPU instruction memory.
//   Receives a byte stream (valid/ready), assembles 16-bit instruction words
//   high byte first and writes them to addresses 0..N-1. The CPU is held in
//   reset from the moment a count byte is accepted until the frame completes.
//
//   Frame: count byte N (0 means 256 words), then 2N data bytes.
//
//   Optional feature macro: IMEM_LOADER_CHECKSUM_EN
//     defined   : a trailing byte equal to the XOR of the count byte and all
//                 data bytes must follow the data; a mismatch sets the sticky
//                 load_err and leaves the CPU held.
//     undefined : no trailing byte, load_err is constant 0.
//
// Ports
//   clk         clock
//   reset       synchronous, active-high reset
//   in_valid    byte on in_data is valid
//   in_data     stream byte
//   in_ready    loader accepts a byte this cycle
//   imem_we     instruction memory write strobe
//   imem_waddr  write address (0 when imem_we=0)
//   imem_wdata  write data    (0 when imem_we=0)
//   cpu_hold    CPU reset request, high while no valid program is present
//   load_done   one-cycle pulse when a load completes successfully
//   load_err    sticky checksum error
//   state_dbg   current FSM state
module imem_loader #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [DATA_W-1:0] imem_wdata,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err,
  output logic [2:0]        state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HI    = 3'd1,
    S_LO    = 3'd2,
    S_WRITE = 3'd3,
    S_CHK   = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
  localparam logic [ADDR_W:0]   IDX_ONE  = (ADDR_W + 1)'(1);

  state_t            state;
  state_t            state_nxt;
  logic              xfer;
  logic [ADDR_W-1:0] word_cnt;   // latched N; 0 encodes 2**ADDR_W words
  logic [ADDR_W:0]   word_idx;
  logic              last_word;
  logic [7:0]        hi_byte;
  logic [7:0]        lo_byte;

  assign xfer = in_valid && in_ready;

  // N-1 computed modulo 2**ADDR_W makes N=0 end at the top address without
  // a special case; the index never exceeds that value, so it cannot wrap.
  assign last_word = (word_idx == {1'b0, word_cnt - ADDR_ONE});

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] csum;
  logic       err_q;
  logic       csum_match;

  assign csum_match = (in_data == csum);
  assign load_err   = err_q;
`else
  assign load_err = 1'b0;
`endif

  // ---- state register ----
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---- next-state logic ----
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (xfer) state_nxt = S_HI;
      S_HI:    if (xfer) state_nxt = S_LO;
      S_LO:    if (xfer) state_nxt = S_WRITE;
      S_WRITE: begin
        if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_nxt = S_CHK;
`else
          state_nxt = S_DONE;
`endif
        end else begin
          state_nxt = S_HI;
        end
      end
      S_CHK: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (xfer) state_nxt = csum_match ? S_DONE : S_IDLE;
`else
        state_nxt = S_IDLE;
`endif
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // ---- outputs ----
  always_comb begin
    in_ready   = 1'b0;
    imem_we    = 1'b0;
    imem_waddr = '0;
    imem_wdata = '0;
    load_done  = 1'b0;
    case (state)
      S_IDLE, S_HI, S_LO, S_CHK: in_ready = 1'b1;
      S_WRITE: begin
        imem_we    = 1'b1;
        imem_waddr = word_idx[ADDR_W-1:0];
        imem_wdata = {hi_byte, lo_byte};
      end
      S_DONE:  load_done = 1'b1;
      default: ;
    endcase
  end

  assign state_dbg = state;

  // ---- control registers: word count, index, CPU hold ----
  always_ff @(posedge clk) begin
    if (reset) begin
      word_cnt <= '0;
      word_idx <= '0;
      cpu_hold <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (xfer) begin
            word_cnt <= in_data;
            word_idx <= '0;
            cpu_hold <= 1'b1;
          end
        end
        S_WRITE: if (!last_word) word_idx <= word_idx + IDX_ONE;
        S_DONE:  cpu_hold <= 1'b0;
        default: ;
      endcase
    end
  end

  // ---- data latches: only read while in WRITE, so no reset needed ----
  always_ff @(posedge clk) begin
    if (state == S_HI && xfer) hi_byte <= in_data;
    if (state == S_LO && xfer) lo_byte <= in_data;
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  // ---- running checksum and sticky error ----
  always_ff @(posedge clk) begin
    if (reset) begin
      csum  <= '0;
      err_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (xfer) begin
            csum  <= in_data;
            err_q <= 1'b0;
          end
        end
        S_HI, S_LO: if (xfer) csum <= csum ^ in_data;
        S_CHK:      if (xfer && !csum_match) err_q <= 1'b1;
        default: ;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader. Expected memory writes are queued as
// each word is driven and popped as the DUT writes them.
module tb_imem_loader;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        imem_we;
  logic [7:0]  imem_waddr;
  logic [15:0] imem_wdata;
  logic        cpu_hold;
  logic        load_done;
  logic        load_err;
  logic [2:0]  state_dbg;

  imem_loader #(.ADDR_W(8), .DATA_W(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .imem_we    (imem_we),
    .imem_waddr (imem_waddr),
    .imem_wdata (imem_wdata),
    .cpu_hold   (cpu_hold),
    .load_done  (load_done),
    .load_err   (load_err),
    .state_dbg  (state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  int          done_cnt = 0;
  int          exp_done = 0;
  time         t_acc = 0;
  time         t_done = 0;
  logic [23:0] exp_q[$];
  logic [15:0] wbuf[256];

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam int LAT_EXP = 15;
`else
  localparam int LAT_EXP = 14;
`endif

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Write monitor / scoreboard, sampled on the falling edge.
  always @(negedge clk) begin
    if (!reset) begin
      if (imem_we) begin
        chk("ready_in_write", {31'd0, in_ready}, 32'd0);
        if (exp_q.size() == 0) begin
          chk("unexpected_write", {8'd0, imem_waddr, imem_wdata}, 32'hFFFF_FFFF);
        end else begin
          chk("write", {8'd0, imem_waddr, imem_wdata}, {8'd0, exp_q.pop_front()});
        end
      end else if (imem_waddr != 8'd0 || imem_wdata != 16'd0) begin
        chk("bus_idle_zero", {8'd0, imem_waddr, imem_wdata}, 32'd0);
      end
      if (load_done) begin
        done_cnt++;
        t_done = $time;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // Drive one byte starting at a falling edge; returns at the falling edge
  // after the accepting rising edge.
  task automatic send_byte(input logic [7:0] b, input bit gap, output time t_hs);
    int  g;
    bit  got;
    t_hs = 0;
    if (gap) begin
      g = $urandom_range(0, 2);
      in_valid = 1'b0;
      repeat (g) @(negedge clk);
    end
    in_valid = 1'b1;
    in_data  = b;
    got = 0;
    for (int i = 0; i < 50 && !got; i++) begin
      if (in_ready) begin
        got  = 1;
        t_hs = $time;
      end
      @(negedge clk);
    end
    if (!got) chk("handshake_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input int n, input bit gap, input bit corrupt);
    logic [7:0] cs;
    logic [7:0] a;
    time        t;
    cs = n[7:0];
    send_byte(n[7:0], gap, t);
    t_acc = t;
    chk("hold_after_count", {31'd0, cpu_hold}, 32'd1);
    for (int k = 0; k < n; k++) begin
      a = k[7:0];
      exp_q.push_back({a, wbuf[k]});
      send_byte(wbuf[k][15:8], gap, t);
      send_byte(wbuf[k][7:0], gap, t);
      cs = cs ^ wbuf[k][15:8] ^ wbuf[k][7:0];
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(corrupt ? (cs ^ 8'h01) : cs, gap, t);
`else
    if (corrupt) chk("corrupt_unsupported", 32'd0, 32'd0 + 32'(corrupt));
`endif
    repeat (3) @(negedge clk);
  endtask

  task automatic check_good_end(input string tag);
    exp_done++;
    chk({tag, "_done_cnt"}, done_cnt, exp_done);
    chk({tag, "_hold"}, {31'd0, cpu_hold}, 32'd0);
    chk({tag, "_err"}, {31'd0, load_err}, 32'd0);
    chk({tag, "_q_empty"}, exp_q.size(), 32'd0);
    chk({tag, "_state"}, {29'd0, state_dbg}, 32'd0);
  endtask

  initial begin
    time t;
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_state",    {29'd0, state_dbg}, 32'd0);
    chk("rst_ready",    {31'd0, in_ready},  32'd1);
    chk("rst_we",       {31'd0, imem_we},   32'd0);
    chk("rst_waddr",    {24'd0, imem_waddr}, 32'd0);
    chk("rst_wdata",    {16'd0, imem_wdata}, 32'd0);
    chk("rst_hold",     {31'd0, cpu_hold},  32'd1);
    chk("rst_done",     {31'd0, load_done}, 32'd0);
    chk("rst_err",      {31'd0, load_err},  32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Basic 4-word load, no gaps.
    wbuf[0] = 16'h1512; wbuf[1] = 16'h2643; wbuf[2] = 16'h3767; wbuf[3] = 16'h4553;
    send_frame(4, 0, 0);
    check_good_end("basic");
    chk("basic_latency", 32'((t_done - t_acc) / 10) + 32'd1, LAT_EXP);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Bad checksum: writes still happen, no completion, error sticks.
    send_frame(4, 0, 1);
    chk("badcs_done_cnt", done_cnt, exp_done);
    chk("badcs_err",   {31'd0, load_err}, 32'd1);
    chk("badcs_hold",  {31'd0, cpu_hold}, 32'd1);
    chk("badcs_state", {29'd0, state_dbg}, 32'd0);
    chk("badcs_q_empty", exp_q.size(), 32'd0);
    send_frame(4, 0, 0);
    check_good_end("recover");
`endif

    // Random gaps and back-pressure with random data.
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 4; k++) wbuf[k] = 16'($urandom);
      send_frame(4, 1, 0);
      check_good_end("gaps");
    end

    // N=0 means 256 words.
    for (int k = 0; k < 256; k++) wbuf[k] = 16'(k * 16'h0101);
    send_frame(256, 0, 0);
    check_good_end("n256");

    // Reset after the high byte of word 2.
    wbuf[0] = 16'h1111; wbuf[1] = 16'h2222; wbuf[2] = 16'h3333;
    send_byte(8'h04, 0, t);
    exp_q.push_back({8'd0, wbuf[0]});
    send_byte(wbuf[0][15:8], 0, t);
    send_byte(wbuf[0][7:0], 0, t);
    exp_q.push_back({8'd1, wbuf[1]});
    send_byte(wbuf[1][15:8], 0, t);
    send_byte(wbuf[1][7:0], 0, t);
    send_byte(wbuf[2][15:8], 0, t);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_state", {29'd0, state_dbg}, 32'd0);
    chk("midrst_hold",  {31'd0, cpu_hold},  32'd1);
    chk("midrst_we",    {31'd0, imem_we},   32'd0);
    repeat (3) @(negedge clk);
    chk("midrst_q_empty", exp_q.size(), 32'd0);
    chk("midrst_done_cnt", done_cnt, exp_done);

    // Follow-up single-word frame.
    wbuf[0] = 16'hABCD;
    send_frame(1, 0, 0);
    check_good_end("oneword");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
